// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the aFIFO write port between NUM_REQ producers.
// A grant covers one burst; words pass straight through with zero latency while granted.

`ifndef bitLength
`define bitLength 8
`endif

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = `bitLength,
  parameter int MAX_BURST = 4,
  localparam int OW       = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_last,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_ack,
  input  logic                      i_wfull,
  output logic                      o_wr,
  output logic [DATA_W-1:0]         o_wdata,
  output logic [OW-1:0]             o_owner,
  output logic                      o_busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]         state_r;
  logic [OW-1:0]      owner_r;
  logic [OW-1:0]      last_owner_r;
  logic [7:0]         beat_r;

  logic               busy_s;
  logic               any_req_s;
  logic               owner_req_s;
  logic               owner_last_s;
  logic               accept_s;
  logic               burst_done_s;
  logic [8:0]         beat_inc_s;
  logic [OW-1:0]      pick_s;
  logic [DATA_W-1:0]  owner_data_s;
  logic [NUM_REQ-1:0] ack_s;

  // Cyclic search for the next requester, starting just after the previous owner
  always_comb begin : rr_pick
    int            sum_v;
    logic          found_v;
    logic [OW-1:0] idx_v;
    pick_s  = '0;
    found_v = 1'b0;
    sum_v   = 0;
    idx_v   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum_v = int'(last_owner_r) + i;
      if (sum_v >= NUM_REQ) begin
        sum_v = sum_v - NUM_REQ;
      end else begin
        sum_v = sum_v;
      end
      idx_v = sum_v[OW-1:0];
      if (!found_v && i_req[idx_v]) begin
        found_v = 1'b1;
        pick_s  = idx_v;
      end else begin
        found_v = found_v;
      end
    end
  end

  assign any_req_s    = |i_req;
  assign busy_s       = (state_r == GRANT);
  assign owner_req_s  = i_req[owner_r];
  assign owner_last_s = i_last[owner_r];
  assign owner_data_s = i_data[int'(owner_r)*DATA_W +: DATA_W];
  assign accept_s     = busy_s & owner_req_s & ~i_wfull;
  assign beat_inc_s   = {1'b0, beat_r} + 9'd1;
  // A last flag coinciding with the beat limit still yields a single burst end
  assign burst_done_s = owner_last_s | (beat_inc_s == 9'(MAX_BURST));

  // One-hot acknowledge to the current owner on an accepted word
  always_comb begin
    ack_s          = '0;
    ack_s[owner_r] = accept_s;
  end

  assign o_wr    = accept_s;
  assign o_wdata = accept_s ? owner_data_s : '0;
  assign o_ack   = ack_s;
  assign o_owner = owner_r;
  assign o_busy  = busy_s;

  // Arbitration state, grant holder and burst beat counting
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      owner_r      <= '0;
      last_owner_r <= OW'(NUM_REQ - 1);
      beat_r       <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r <= pick_s;
            beat_r  <= 8'd0;
            state_r <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req_s) begin
            // withdrawal forfeits the turn
            last_owner_r <= owner_r;
            state_r      <= IDLE;
          end else if (!i_wfull) begin
            beat_r <= beat_inc_s[7:0];
            if (burst_done_s) begin
              last_owner_r <= owner_r;
              state_r      <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
